// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : Load/store controller between the execute stage and data memory.
//             Handles alignment checks, byte masks, load extension and
//             store-data forwarding.
//  Revision : 1.0
// ============================================================================
module mem_access_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic        io_req_store,
    input  logic [2:0]  io_req_funct3,
    input  logic [31:0] io_req_addr,
    input  logic [4:0]  io_req_rs2_addr,
    input  logic [4:0]  io_prev_rd,
    input  logic        io_prev_wen,
    input  logic        io_prev_is_load,
    output logic [1:0]  io_dmem_sel,
    output logic        io_mem_valid,
    output logic        io_mem_we,
    output logic [31:0] io_mem_addr,
    output logic [3:0]  io_mem_wmask,
    input  logic        io_mem_ready,
    input  logic        io_mem_rvalid,
    input  logic [31:0] io_mem_rdata,
    output logic        io_stall,
    output logic        io_load_valid,
    output logic [31:0] io_load_data,
    output logic        io_store_done,
    output logic        io_misaligned
);

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    localparam logic [1:0] c_sel_alu = 2'd0;
    localparam logic [1:0] c_sel_rs2 = 2'd1;
    localparam logic [1:0] c_sel_mem = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT_R = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [1:0]  r_sel;
    logic [31:0] r_load_data;
    logic        r_store_done;
    logic        r_misaligned;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_rs2_hit;
    logic [1:0]  w_sel;
    logic [3:0]  w_wmask;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign io_req_ready = (r_state == S_IDLE);
    assign w_accept     = io_req_valid & io_req_ready;

    // Unlisted funct3 codes are reported through the misaligned exception path.
    always_comb begin
        w_misaligned = 1'b1;
        case (io_req_funct3)
            c_f3_b, c_f3_bu: w_misaligned = 1'b0;
            c_f3_h, c_f3_hu: w_misaligned = io_req_addr[0];
            c_f3_w:          w_misaligned = (io_req_addr[1:0] != 2'b00);
            default:         w_misaligned = 1'b1;
        endcase
    end

    // A load still in flight ahead of us forces the store data to come from memory.
    assign w_rs2_hit = io_prev_wen && (io_prev_rd == io_req_rs2_addr) && (io_req_rs2_addr != 5'd0);

    always_comb begin
        w_sel = c_sel_rs2;
        if (w_rs2_hit && io_prev_is_load) begin
            w_sel = c_sel_mem;
        end else if (w_rs2_hit) begin
            w_sel = c_sel_alu;
        end
    end

    always_comb begin
        w_wmask = 4'b0000;
        if (r_store) begin
            case (r_funct3[1:0])
                2'b00:   w_wmask = 4'b0001 << r_addr[1:0];
                2'b01:   w_wmask = 4'b0011 << {r_addr[1], 1'b0};
                2'b10:   w_wmask = 4'b1111;
                default: w_wmask = 4'b0000;
            endcase
        end
    end

    always_comb begin
        w_byte = io_mem_rdata[7:0];
        case (r_addr[1:0])
            2'b00:   w_byte = io_mem_rdata[7:0];
            2'b01:   w_byte = io_mem_rdata[15:8];
            2'b10:   w_byte = io_mem_rdata[23:16];
            default: w_byte = io_mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? io_mem_rdata[31:16] : io_mem_rdata[15:0];
        w_ext  = io_mem_rdata;
        case (r_funct3)
            c_f3_b:  w_ext = {{24{w_byte[7]}}, w_byte};
            c_f3_bu: w_ext = {24'd0, w_byte};
            c_f3_h:  w_ext = {{16{w_half[15]}}, w_half};
            c_f3_hu: w_ext = {16'd0, w_half};
            default: w_ext = io_mem_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_store      <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_sel        <= c_sel_rs2;
            r_load_data  <= 32'd0;
            r_store_done <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_store_done <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_store  <= io_req_store;
                        r_funct3 <= io_req_funct3;
                        r_addr   <= io_req_addr;
                        r_sel    <= w_sel;
                        if (w_misaligned) begin
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (io_mem_ready) begin
                        if (r_store) begin
                            r_store_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT_R;
                        end
                    end
                end
                S_WAIT_R: begin
                    if (io_mem_rvalid) begin
                        r_load_data <= w_ext;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_mem_valid  = (r_state == S_ISSUE);
    assign io_mem_we     = io_mem_valid & r_store;
    assign io_mem_addr   = io_mem_valid ? {r_addr[31:2], 2'b00} : 32'd0;
    assign io_mem_wmask  = io_mem_valid ? w_wmask : 4'b0000;
    assign io_dmem_sel   = io_mem_valid ? r_sel : c_sel_rs2;
    assign io_stall      = (r_state == S_ISSUE) || (r_state == S_WAIT_R) ||
                           ((r_state == S_IDLE) && io_req_valid && !w_misaligned);
    assign io_load_valid = (r_state == S_RESP);
    assign io_load_data  = io_load_valid ? r_load_data : 32'd0;
    assign io_store_done = r_store_done;
    assign io_misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL provide: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: io_req_valid  in  1  load/store request from execute stage.
REQ-004 SHALL provide: io_req_ready  out  1  controller idle, request accepted this cycle if valid.
REQ-005 SHALL provide: io_req_store  in  1  1 = store, 0 = load.
REQ-006 SHALL provide: io_req_funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL provide: io_req_addr  in  32  byte address.
REQ-008 SHALL provide: io_req_rs2_addr  in  5  store-data source register.
REQ-009 SHALL provide: io_prev_rd, io_prev_wen, io_prev_is_load  in  5/1/1  destination of the older in-flight instruction.
REQ-010 SHALL provide: io_dmem_sel  out  2  store-data mux select (0 alu_out, 1 rs2, 2 mem_out).
REQ-011 SHALL provide: io_mem_valid, io_mem_we  out  1/1  memory command valid / write enable.
REQ-012 SHALL provide: io_mem_addr  out  32  word-aligned address (addr[1:0] forced 0).
REQ-013 SHALL provide: io_mem_wmask  out  4  byte write enables.
REQ-014 SHALL provide: io_mem_ready, io_mem_rvalid  in  1/1  command accepted / read data valid.
REQ-015 SHALL provide: io_mem_rdata  in  32  read word.
REQ-016 SHALL provide: io_stall  out  1  pipeline hold.
REQ-017 SHALL provide: io_load_valid, io_load_data  out  1/32  load result pulse, extended data.
REQ-018 SHALL provide: io_store_done, io_misaligned  out  1/1  one-cycle completion/exception pulses.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_R, RESP.
REQ-020 SHALL assert io_req_ready only in IDLE; accept = io_req_valid & io_req_ready.
REQ-021 SHALL on accept capture store, funct3, addr, rs2_addr and computed select into registers.
REQ-022 SHALL treat a request as misaligned when H/HU and addr[0]=1, or W and addr[1:0]!=0; also any funct3 outside the five listed codes.
REQ-023 SHALL on misaligned accept stay in IDLE, issue no memory command, and pulse io_misaligned the next cycle.
REQ-024 SHALL on aligned accept go to ISSUE next cycle.
REQ-025 SHALL in ISSUE drive io_mem_valid=1, io_mem_we=store, held stable until io_mem_ready=1.
REQ-026 SHALL on ISSUE & mem_ready: store -> IDLE with io_store_done pulsed next cycle; load -> WAIT_R.
REQ-027 SHALL in WAIT_R wait indefinitely for io_mem_rvalid; on rvalid register extended data and go to RESP.
REQ-028 SHALL in RESP pulse io_load_valid=1 for exactly one cycle with io_load_data, then return to IDLE.
REQ-029 SHALL ignore io_mem_rvalid outside WAIT_R.
REQ-030 SHALL wmask: SB = 0001 << addr[1:0]; SH = 0011 << {addr[1],0}; SW = 1111; loads 0000.
REQ-031 SHALL extract loads by captured addr[1:0]: B/H sign-extend, BU/HU zero-extend, W passthrough.
REQ-032 SHALL select io_dmem_sel at accept: 2 if prev_wen & prev_is_load & prev_rd==rs2_addr & rs2_addr!=0; else 0 if prev_wen & prev_rd==rs2_addr & rs2_addr!=0; else 1.
REQ-033 SHALL hold io_dmem_sel at the captured value in ISSUE and drive 1 in all other states.
REQ-034 SHALL assert io_stall in ISSUE, WAIT_R, and IDLE while io_req_valid is high with an aligned request.
REQ-035 SHALL give minimum latency: store accept->done 2 cycles; load accept->load_valid 3 cycles with zero-wait memory.

Reset
REQ-036 SHALL on reset go to IDLE; all outputs 0 except io_req_ready=1 and io_dmem_sel=1.
REQ-037 SHALL on reset mid-operation abandon the transaction: mem_valid drops the cycle after reset is sampled; no done/load_valid pulse; late rvalid ignored.

Verification
REQ-038 SHALL cover SW addr 0x100, rs2=x5, no hazard, mem_ready immediate -> mem_addr 0x100, wmask 1111, sel 1, store_done 2 cycles after accept.
REQ-039 SHALL cover SB addr 0x103 with prev_rd=x5 load, rs2=x5 -> wmask 1000, sel 2 during ISSUE.
REQ-040 SHALL cover LB addr 0x102, rdata 0x00800000 -> load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-041 SHALL cover LH addr 0x101 -> io_misaligned pulse, no mem_valid, req_ready stays 1.
REQ-042 SHALL cover mem_ready held low 4 cycles in ISSUE -> mem_valid, addr, wmask, sel stable, stall=1 throughout.
REQ-043 SHALL cover reset asserted in WAIT_R then rvalid -> IDLE, load_valid never asserted.
